// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data-memory port between the IFU (fetch) and
// the LSU (load/store). One transaction in flight at a time, LSU has priority,
// and a starvation counter lets a pending fetch through after STARVE_LIMIT
// back-to-back LSU grants.
//
// Handshakes: a request channel transfers on a cycle where valid && ready are
// both high at the rising edge; mem_req_valid is held with stable fields until
// mem_req_ready; response pulses are one cycle wide and are not back-pressured.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a REQ/WAIT timeout that
// returns an error response after TIMEOUT_CYC cycles.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC  = 255
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic              owner_lsu;
    logic [SC_W-1:0]   starve_cnt;
    logic              idle;
    logic              starve_full;
    logic              ifu_go;
    logic              lsu_go;
    logic              tmo_hit;
    logic              fin_real;
    logic              fin;
    logic              fin_err;
    logic [DATA_W-1:0] fin_rdata;

    assign idle        = (state == IDLE);
    assign starve_full = (starve_cnt == SC_W'(STARVE_LIMIT));

    // LSU wins unless a starved fetch is pending; the two readies are never
    // both usable in one cycle, so at most one grant happens per edge.
    assign ifu_req_ready = idle && !rst && (!lsu_req_valid || starve_full);
    assign lsu_req_ready = idle && !rst && !(ifu_req_valid && starve_full);
    assign ifu_go        = ifu_req_valid && ifu_req_ready;
    assign lsu_go        = lsu_req_valid && lsu_req_ready;

    assign busy      = !idle;
    assign state_dbg = state;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;

    // Per-transaction cycle counter: 0 in the first REQ cycle, so the error
    // response (registered one edge later) lands TIMEOUT_CYC cycles after accept.
    always_ff @(posedge clk) begin
        if (rst || ifu_go || lsu_go) begin
            tmo_cnt <= '0;
        end else if (!idle) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = !idle && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 2));
`else
    assign tmo_hit = 1'b0;
`endif

    // A real memory response in WAIT always beats a coincident timeout.
    assign fin_real  = (state == WAIT) && mem_resp_valid;
    assign fin       = fin_real || tmo_hit;
    assign fin_err   = fin_real ? mem_resp_err : 1'b1;
    assign fin_rdata = (fin_real && !(owner_lsu && mem_wen)) ? mem_rdata : '0;

    // Arbitration FSM with registered memory request and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner_lsu      <= 1'b0;
            starve_cnt     <= '0;
            mem_req_valid  <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            if (fin) begin
                state         <= IDLE;
                mem_req_valid <= 1'b0;
                if (owner_lsu) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= fin_rdata;
                    lsu_resp_err   <= fin_err;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= fin_rdata;
                    ifu_resp_err   <= fin_err;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (lsu_go) begin
                            owner_lsu     <= 1'b1;
                            mem_req_valid <= 1'b1;
                            mem_wen       <= lsu_wen;
                            mem_addr      <= lsu_addr;
                            mem_wdata     <= lsu_wdata;
                            mem_wmask     <= lsu_wmask;
                            state         <= REQ;
                            if (ifu_req_valid && !starve_full) begin
                                starve_cnt <= starve_cnt + SC_W'(1);
                            end
                        end else if (ifu_go) begin
                            owner_lsu     <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_wen       <= 1'b0;
                            mem_addr      <= ifu_addr;
                            mem_wdata     <= '0;
                            mem_wmask     <= '0;
                            state         <= REQ;
                            starve_cnt    <= '0;
                        end
                    end
                    REQ: begin
                        if (mem_req_ready) begin
                            mem_req_valid <= 1'b0;
                            state         <= WAIT;
                        end
                    end
                    WAIT: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors plus hand-written multi-cycle sequences
// for mem_arbiter. Inputs change 1 time unit after posedge; outputs are
// sampled on negedge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;
    logic        busy;
    logic [1:0]  state_dbg;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        is_lsu;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] mrdata;
        logic        merr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .mem_resp_err(mem_resp_err),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reset held for two edges; readies must stay low while rst is high.
    task automatic do_reset();
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_rdata      = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One isolated transaction against a zero-wait memory; starts and ends
    // 1 time unit after a posedge with the DUT idle.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_rd;
        string       tag;
        tag      = $sformatf("vec%0d", idx);
        ifu_addr = v.addr;
        lsu_addr = v.addr;
        lsu_wen  = v.wen;
        lsu_wdata = v.wdata;
        lsu_wmask = v.wmask;
        if (v.is_lsu) lsu_req_valid = 1'b1;
        else          ifu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        exp_q.push_back(v.exp_rdata);
        @(negedge clk);
        if (v.is_lsu) check({tag, "_lsu_ready"}, 64'(lsu_req_ready), 64'd1);
        else          check({tag, "_ifu_ready"}, 64'(ifu_req_ready), 64'd1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd1);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(v.addr));
        check({tag, "_mem_wen"}, 64'(mem_wen), 64'(v.exp_wen));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
        check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'(v.exp_wmask));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_rdata      = v.mrdata;
        mem_resp_err   = v.merr;
        @(negedge clk);
        check({tag, "_mem_req_dropped"}, 64'(mem_req_valid), 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0BAD_0BAD;
        mem_resp_err   = 1'b0;
        @(negedge clk);
        exp_rd = exp_q.pop_front();
        if (v.is_lsu) begin
            check({tag, "_lsu_resp_valid"}, 64'(lsu_resp_valid), 64'd1);
            check({tag, "_ifu_resp_quiet"}, 64'(ifu_resp_valid), 64'd0);
            check({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'(exp_rd));
            check({tag, "_lsu_err"}, 64'(lsu_resp_err), 64'(v.exp_err));
        end else begin
            check({tag, "_ifu_resp_valid"}, 64'(ifu_resp_valid), 64'd1);
            check({tag, "_lsu_resp_quiet"}, 64'(lsu_resp_valid), 64'd0);
            check({tag, "_ifu_rdata"}, 64'(ifu_rdata), 64'(exp_rd));
            check({tag, "_ifu_err"}, 64'(ifu_resp_err), 64'(v.exp_err));
        end
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        if (v.is_lsu) begin
            check({tag, "_lsu_pulse_end"}, 64'(lsu_resp_valid), 64'd0);
            check({tag, "_lsu_rdata_hold"}, 64'(lsu_rdata), 64'(exp_rd));
        end else begin
            check({tag, "_ifu_pulse_end"}, 64'(ifu_resp_valid), 64'd0);
            check({tag, "_ifu_rdata_hold"}, 64'(ifu_rdata), 64'(exp_rd));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic exp_lsu;
        int   first_k;
        total    = 0;
        bad      = 0;
        ifu_addr = '0;
        lsu_wen  = 1'b0;
        lsu_addr = '0;
        lsu_wdata = '0;
        lsu_wmask = '0;

        //                 lsu   wen   addr          wdata         mask  mrdata        merr  e_wen e_wdata       e_mask e_rdata      e_err
        vecs[0] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0413, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0413, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_0200, 32'hAAAA_5555, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hAAAA_5555, 4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0102_0304, 4'h3, 32'h5555_AAAA, 1'b0, 1'b1, 32'h0102_0304, 4'h3, 32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 4'hF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0001, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111, 4'h5, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h7FFF_FFFF, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h8, 32'h0000_1234, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'h8, 32'h0000_0000, 1'b1};

        // Readies gated by reset even though the FSM sits in IDLE
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_rdata      = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        check("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
        check("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_ifu_rdata", 64'(ifu_rdata), 64'd0);
        check("rst_lsu_rdata", 64'(lsu_rdata), 64'd0);
        do_reset();

        // Table-driven single transactions (vec0 is the plain fetch case)
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Simultaneous requests: LSU store wins, IFU follows
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wdata     = 32'h1234_5678;
        lsu_wmask     = 4'hF;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("both_lsu_ready", 64'(lsu_req_ready), 64'd1);
        check("both_ifu_ready", 64'(ifu_req_ready), 64'd0);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check("both_mem_wen", 64'(mem_wen), 64'd1);
        check("both_mem_addr", 64'(mem_addr), 64'h8000_0100);
        check("both_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
        check("both_mem_wmask", 64'(mem_wmask), 64'hF);
        check("both_ifu_ready_busy", 64'(ifu_req_ready), 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("both_lsu_resp", 64'(lsu_resp_valid), 64'd1);
        check("both_lsu_store_rdata", 64'(lsu_rdata), 64'd0);
        check("both_ifu_resp_quiet", 64'(ifu_resp_valid), 64'd0);
        check("both_ifu_ready_after", 64'(ifu_req_ready), 64'd1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(negedge clk);
        check("both_ifu_mem_addr", 64'(mem_addr), 64'h8000_0004);
        check("both_ifu_mem_wen", 64'(mem_wen), 64'd0);
        check("both_ifu_mem_wdata", 64'(mem_wdata), 64'd0);
        check("both_ifu_mem_wmask", 64'(mem_wmask), 64'd0);
        check("both_lsu_pulse_end", 64'(lsu_resp_valid), 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0013;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("both_ifu_resp", 64'(ifu_resp_valid), 64'd1);
        check("both_ifu_rdata", 64'(ifu_rdata), 64'h13);

        // Starvation: both held valid; expect L L L L I L L L L I
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0040;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h0000_0080;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("starve_g0_lsu_ready", 64'(lsu_req_ready), 64'd1);
        check("starve_g0_ifu_ready", 64'(ifu_req_ready), 64'd0);
        for (int g = 0; g < 10; g++) begin
            exp_lsu = ((g % 5) != 4);
            @(posedge clk); #1;
            @(posedge clk); #1;
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hA000 + 32'(g);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            @(negedge clk);
            check($sformatf("starve_g%0d_lsu_resp", g), 64'(lsu_resp_valid), 64'(exp_lsu));
            check($sformatf("starve_g%0d_ifu_resp", g), 64'(ifu_resp_valid), 64'(!exp_lsu));
            if (g < 9) begin
                exp_lsu = (((g + 1) % 5) != 4);
                check($sformatf("starve_g%0d_lsu_ready", g + 1), 64'(lsu_req_ready), 64'(exp_lsu));
                check($sformatf("starve_g%0d_ifu_ready", g + 1), 64'(ifu_req_ready), 64'(!exp_lsu));
            end
        end

        // Memory stall: fields stable, no readies, stray response in REQ dropped
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h0000_0040;
        lsu_wdata     = 32'h0BAD_F00D;
        lsu_wmask     = 4'hC;
        mem_req_ready = 1'b0;
        @(posedge clk); #1;
        lsu_addr      = 32'h0000_0044;
        lsu_wdata     = 32'h0;
        ifu_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_resp_valid = (k == 2);
            mem_rdata      = 32'h7777_7777;
            @(negedge clk);
            check($sformatf("stall%0d_req_valid", k), 64'(mem_req_valid), 64'd1);
            check($sformatf("stall%0d_addr", k), 64'(mem_addr), 64'h40);
            check($sformatf("stall%0d_wdata", k), 64'(mem_wdata), 64'h0BAD_F00D);
            check($sformatf("stall%0d_wmask", k), 64'(mem_wmask), 64'hC);
            check($sformatf("stall%0d_wen", k), 64'(mem_wen), 64'd1);
            check($sformatf("stall%0d_lsu_ready", k), 64'(lsu_req_ready), 64'd0);
            check($sformatf("stall%0d_ifu_ready", k), 64'(ifu_req_ready), 64'd0);
            check($sformatf("stall%0d_lsu_resp", k), 64'(lsu_resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        lsu_req_valid  = 1'b0;
        ifu_req_valid  = 1'b0;
        @(negedge clk);
        check("stall_end_req_valid", 64'(mem_req_valid), 64'd1);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("stall_lsu_resp", 64'(lsu_resp_valid), 64'd1);
        check("stall_lsu_rdata", 64'(lsu_rdata), 64'd0);

        // Reset in the middle of WAIT, then a late memory response
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0100;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midwait_busy", 64'(busy), 64'd1);
        check("midwait_state", 64'(state_dbg), 64'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0055;
        @(negedge clk);
        check("rstwait_busy", 64'(busy), 64'd0);
        check("rstwait_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rstwait_ifu_resp", 64'(ifu_resp_valid), 64'd0);
        check("rstwait_lsu_resp", 64'(lsu_resp_valid), 64'd0);
        check("rstwait_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("late_ifu_resp", 64'(ifu_resp_valid), 64'd0);
        check("late_lsu_resp", 64'(lsu_resp_valid), 64'd0);
        check("late_busy", 64'(busy), 64'd0);
        check("late_ifu_rdata", 64'(ifu_rdata), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never accepts: error response 16 cycles after accept
        do_reset();
        first_k       = 0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0200;
        mem_req_ready = 1'b0;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ifu_resp_valid && first_k == 0) begin
                first_k = k;
                check("tmo_err", 64'(ifu_resp_err), 64'd1);
                check("tmo_rdata", 64'(ifu_rdata), 64'd0);
                check("tmo_mem_req_valid", 64'(mem_req_valid), 64'd0);
                check("tmo_busy", 64'(busy), 64'd0);
            end
            @(posedge clk); #1;
        end
        check("tmo_latency", 64'(first_k), 64'd16);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0099;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("tmo_late_resp", 64'(ifu_resp_valid), 64'd0);
`else
        first_k = 0;
        exp_lsu = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
